// File: rtl/rr_mux_4to1_pkg.sv
// rr_mux_4to1_pkg: shared constants for the 4-channel round-robin merger
package rr_mux_4to1_pkg;
   localparam int N_CH = 4;
   localparam int SEL_W = 2;
   localparam logic [SEL_W-1:0] RST_PTR = 2'd3;
endpackage

// File: rtl/rr_mux_4to1_if.sv
// rr_mux_4to1_if: four input streams plus one tagged output stream
interface rr_mux_4to1_if
   import rr_mux_4to1_pkg::*;
#(
   parameter int DATA_W = 8
) ();
   logic [N_CH-1:0]        in_valid;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic [DATA_W-1:0]      out_data;
   logic [SEL_W-1:0]       out_sel;
   logic                   out_ready;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/rr_mux_4to1_arbiter.sv
// rr_arbiter_4: combinational round-robin pick, searching from last_grant+1 with wrap
module rr_arbiter_4
   import rr_mux_4to1_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last_grant,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt_idx
);
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx = '0;
      // walk from farthest to nearest so the nearest requester wins
      for (int i = N_CH; i >= 1; i--) begin
         if (req[last_grant + SEL_W'(i)]) begin
            gnt_valid = 1'b1;
            gnt_idx = last_grant + SEL_W'(i);
         end
      end
   end
endmodule

// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1: round-robin 4:1 stream merger with registered, channel-tagged output
module rr_mux_4to1
   import rr_mux_4to1_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input logic clk,
   input logic rst,
   rr_mux_4to1_if.slave bus
);
   logic [SEL_W-1:0]  last_grant, gnt_idx, sel_q;
   logic              gnt_valid, load_ok, valid_q;
   logic [DATA_W-1:0] data_q;
   rr_arbiter_4 u_arb (
      .req        (bus.in_valid),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );
   assign load_ok = !valid_q || bus.out_ready;
   assign bus.in_ready = (!rst && load_ok && gnt_valid) ? N_CH'(1) << gnt_idx : '0;
   assign bus.out_valid = valid_q;
   assign bus.out_data = data_q;
   assign bus.out_sel = sel_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q <= '0;
         sel_q <= '0;
         last_grant <= RST_PTR;
      end else if (load_ok && gnt_valid) begin
         valid_q <= 1'b1;
         data_q <= bus.in_data[gnt_idx*DATA_W +: DATA_W];
         sel_q <= gnt_idx;
         last_grant <= gnt_idx;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end
endmodule
